// File: rtl/ares_mem_pkg.sv
// Shared types and default geometry for the complex sample memories.
// A sample is stored packed as {real, imag}, real in the upper half.
package ares_mem_pkg;

  localparam int CPLX_DATA_W = 16;
  localparam int CPLX_ADDR_W = 12;

  typedef struct packed {
    logic signed [CPLX_DATA_W-1:0] re;
    logic signed [CPLX_DATA_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/cplx_tdp_bank.sv
// One true dual-port, read-first complex sample bank with registered reads.
// Both ports read the pre-write contents when they share an address with a write.
module cplx_tdp_bank
  import ares_mem_pkg::*;
#(
  parameter int DATA_W = CPLX_DATA_W,
  parameter int ADDR_W = CPLX_ADDR_W
) (
  input  logic                clk,
  input  logic                i_a_we,
  input  logic [ADDR_W-1:0]   i_a_addr,
  input  logic [2*DATA_W-1:0] i_a_wdata,
  output logic [2*DATA_W-1:0] o_a_rdata,
  input  logic                i_b_we,
  input  logic [ADDR_W-1:0]   i_b_addr,
  input  logic [2*DATA_W-1:0] i_b_wdata,
  output logic [2*DATA_W-1:0] o_b_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  (* ramstyle = "M10K" *) logic [2*DATA_W-1:0] r_mem [0:DEPTH-1];

  // Reads sample the array before this edge's writes land, giving read-first behaviour.
  always_ff @(posedge clk) begin
    o_a_rdata <= r_mem[i_a_addr];
    o_b_rdata <= r_mem[i_b_addr];
    if (i_a_we) r_mem[i_a_addr] <= i_a_wdata;
    if (i_b_we) r_mem[i_b_addr] <= i_b_wdata;
  end

endmodule

// File: rtl/cplx_pingpong_ram.sv
// Double-buffered complex sample memory: one bank fills from the input stream
// while the other is processed through two ports; roles swap by handshake.
module cplx_pingpong_ram
  import ares_mem_pkg::*;
#(
  parameter int DATA_W  = CPLX_DATA_W,
  parameter int ADDR_W  = CPLX_ADDR_W,
  parameter int OUT_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_we,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  input  logic                     in_done,
  output logic                     in_ready,
  output logic                     in_overflow,
  input  logic                     a_re,
  input  logic                     a_we,
  input  logic [ADDR_W-1:0]        a_addr,
  input  logic signed [DATA_W-1:0] a_din_real,
  input  logic signed [DATA_W-1:0] a_din_imag,
  output logic signed [DATA_W-1:0] a_dout_real,
  output logic signed [DATA_W-1:0] a_dout_imag,
  output logic                     a_valid,
  input  logic                     b_re,
  input  logic                     b_we,
  input  logic [ADDR_W-1:0]        b_addr,
  input  logic signed [DATA_W-1:0] b_din_real,
  input  logic signed [DATA_W-1:0] b_din_imag,
  output logic signed [DATA_W-1:0] b_dout_real,
  output logic signed [DATA_W-1:0] b_dout_imag,
  output logic                     b_valid,
  output logic                     work_full,
  input  logic                     work_done,
  output logic                     swap,
  output logic                     collision
);

  localparam int W = 2 * DATA_W;

  logic r_sel;
  logic r_fill_full;
  logic r_work_full;
  logic r_swap;
  logic r_collision;
  logic r_in_overflow;
  logic r_a_v1;
  logic r_b_v1;
  logic r_rd_bank;

  logic         w_swap_cond;
  logic         w_fill_wr;
  logic         w_a_wr;
  logic         w_b_wr;
  logic         w_collision;
  logic [W-1:0] w_q_a [2];
  logic [W-1:0] w_q_b [2];
  logic [W-1:0] w_a_q;
  logic [W-1:0] w_b_q;
  logic [W-1:0] w_a_dout;
  logic [W-1:0] w_b_dout;
  logic         w_a_valid;
  logic         w_b_valid;

  assign w_swap_cond = r_fill_full & ~r_work_full;
  assign w_fill_wr   = in_we & ~r_fill_full;
  assign w_collision = r_work_full & a_we & b_we & (a_addr == b_addr);
  assign w_a_wr      = r_work_full & a_we;
  // Port A wins a same-address write; port B's data is discarded.
  assign w_b_wr      = r_work_full & b_we & ~w_collision;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel         <= 1'b0;
      r_fill_full   <= 1'b0;
      r_work_full   <= 1'b0;
      r_swap        <= 1'b0;
      r_collision   <= 1'b0;
      r_in_overflow <= 1'b0;
    end else begin
      r_swap        <= w_swap_cond;
      r_collision   <= w_collision;
      r_in_overflow <= r_fill_full & (in_we | in_done);
      if (w_swap_cond) begin
        r_sel       <= ~r_sel;
        r_fill_full <= 1'b0;
        r_work_full <= 1'b1;
      end else begin
        if (in_done)   r_fill_full <= 1'b1;
        if (work_done) r_work_full <= 1'b0;
      end
    end
  end

  // The work bank at issue time is remembered so a swap cannot redirect read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_v1    <= 1'b0;
      r_b_v1    <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      r_a_v1    <= a_re & r_work_full;
      r_b_v1    <= b_re & r_work_full;
      r_rd_bank <= ~r_sel;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    logic w_is_fill;
    assign w_is_fill = (r_sel == (g == 1));

    cplx_tdp_bank #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk       (clk),
      .i_a_we    (w_is_fill ? w_fill_wr : w_a_wr),
      .i_a_addr  (w_is_fill ? in_addr : a_addr),
      .i_a_wdata (w_is_fill ? {in_real, in_imag} : {a_din_real, a_din_imag}),
      .o_a_rdata (w_q_a[g]),
      .i_b_we    (~w_is_fill & w_b_wr),
      .i_b_addr  (b_addr),
      .i_b_wdata ({b_din_real, b_din_imag}),
      .o_b_rdata (w_q_b[g])
    );
  end

  assign w_a_q = r_rd_bank ? w_q_a[1] : w_q_a[0];
  assign w_b_q = r_rd_bank ? w_q_b[1] : w_q_b[0];

  if (OUT_REG != 0) begin : g_out_reg
    logic         r_a_v2;
    logic         r_b_v2;
    logic [W-1:0] r_a_out;
    logic [W-1:0] r_b_out;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_a_v2  <= 1'b0;
        r_b_v2  <= 1'b0;
        r_a_out <= '0;
        r_b_out <= '0;
      end else begin
        r_a_v2 <= r_a_v1;
        r_b_v2 <= r_b_v1;
        if (r_a_v1) r_a_out <= w_a_q;
        if (r_b_v1) r_b_out <= w_b_q;
      end
    end

    assign w_a_valid = r_a_v2;
    assign w_b_valid = r_b_v2;
    assign w_a_dout  = r_a_out;
    assign w_b_dout  = r_b_out;
  end else begin : g_no_out_reg
    logic [W-1:0] r_a_hold;
    logic [W-1:0] r_b_hold;

    // Bank data passes straight through when valid; otherwise the last value is held.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_a_hold <= '0;
        r_b_hold <= '0;
      end else begin
        if (r_a_v1) r_a_hold <= w_a_q;
        if (r_b_v1) r_b_hold <= w_b_q;
      end
    end

    assign w_a_valid = r_a_v1;
    assign w_b_valid = r_b_v1;
    assign w_a_dout  = r_a_v1 ? w_a_q : r_a_hold;
    assign w_b_dout  = r_b_v1 ? w_b_q : r_b_hold;
  end

  assign in_ready    = ~r_fill_full;
  assign in_overflow = r_in_overflow;
  assign work_full   = r_work_full;
  assign swap        = r_swap;
  assign collision   = r_collision;
  assign a_valid     = w_a_valid;
  assign b_valid     = w_b_valid;
  assign a_dout_real = w_a_dout[W-1:DATA_W];
  assign a_dout_imag = w_a_dout[DATA_W-1:0];
  assign b_dout_real = w_b_dout[W-1:DATA_W];
  assign b_dout_imag = w_b_dout[DATA_W-1:0];

endmodule

// File: tb/tb_cplx_pingpong_ram.sv
// Directed-plus-random bench for cplx_pingpong_ram; two behavioural bank arrays
// track what every address should hold, the fill bank index tracks the roles.
module tb_cplx_pingpong_ram;
  import ares_mem_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_we = 1'b0;
  logic [AW-1:0]        in_addr = '0;
  logic signed [DW-1:0] in_real = '0;
  logic signed [DW-1:0] in_imag = '0;
  logic                 in_done = 1'b0;
  logic                 in_ready;
  logic                 in_overflow;
  logic                 a_re = 1'b0;
  logic                 a_we = 1'b0;
  logic [AW-1:0]        a_addr = '0;
  logic signed [DW-1:0] a_din_real = '0;
  logic signed [DW-1:0] a_din_imag = '0;
  logic signed [DW-1:0] a_dout_real;
  logic signed [DW-1:0] a_dout_imag;
  logic                 a_valid;
  logic                 b_re = 1'b0;
  logic                 b_we = 1'b0;
  logic [AW-1:0]        b_addr = '0;
  logic signed [DW-1:0] b_din_real = '0;
  logic signed [DW-1:0] b_din_imag = '0;
  logic signed [DW-1:0] b_dout_real;
  logic signed [DW-1:0] b_dout_imag;
  logic                 b_valid;
  logic                 work_full;
  logic                 work_done = 1'b0;
  logic                 swap;
  logic                 collision;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [2*DW-1:0] modelMem [0:1][0:DEPTH-1];
  int              fillIdx;

  always #5 clk = ~clk;

  cplx_pingpong_ram #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .OUT_REG (0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_we       (in_we),
    .in_addr     (in_addr),
    .in_real     (in_real),
    .in_imag     (in_imag),
    .in_done     (in_done),
    .in_ready    (in_ready),
    .in_overflow (in_overflow),
    .a_re        (a_re),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_din_real  (a_din_real),
    .a_din_imag  (a_din_imag),
    .a_dout_real (a_dout_real),
    .a_dout_imag (a_dout_imag),
    .a_valid     (a_valid),
    .b_re        (b_re),
    .b_we        (b_we),
    .b_addr      (b_addr),
    .b_din_real  (b_din_real),
    .b_din_imag  (b_din_imag),
    .b_dout_real (b_dout_real),
    .b_dout_imag (b_dout_imag),
    .b_valid     (b_valid),
    .work_full   (work_full),
    .work_done   (work_done),
    .swap        (swap),
    .collision   (collision)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advances n clock edges; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fillFrame(input int kind, input int count);
    cplx_t s;
    for (int k = 0; k < count; k++) begin
      case (kind)
        0: begin
          s.re = 16'(k);
          s.im = -s.re;
        end
        1: begin
          s.re = 16'(100 + k);
          s.im = '0;
        end
        default: s = cplx_t'($urandom);
      endcase
      in_we   = 1'b1;
      in_addr = AW'(k);
      in_real = s.re;
      in_imag = s.im;
      applyStimulus(1);
      modelMem[fillIdx][k] = s;
    end
    in_we = 1'b0;
  endtask

  task automatic readCheck(input string tag, input int ra, input int rb);
    a_re   = 1'b1;
    b_re   = 1'b1;
    a_addr = AW'(ra);
    b_addr = AW'(rb);
    applyStimulus(1);
    a_re = 1'b0;
    b_re = 1'b0;
    checkOutput({tag, "_avalid"}, 32'(a_valid), 32'd1);
    checkOutput({tag, "_bvalid"}, 32'(b_valid), 32'd1);
    checkOutput({tag, "_adata"}, {a_dout_real, a_dout_imag}, modelMem[1-fillIdx][ra]);
    checkOutput({tag, "_bdata"}, {b_dout_real, b_dout_imag}, modelMem[1-fillIdx][rb]);
  endtask

  // Pulses in_done on an empty-work state and expects the swap on the following edge.
  task automatic doneAndSwap(input string tag);
    in_done = 1'b1;
    applyStimulus(1);
    in_done = 1'b0;
    checkOutput({tag, "_ready_lo"}, 32'(in_ready), 32'd0);
    checkOutput({tag, "_noswap_yet"}, 32'(swap), 32'd0);
    applyStimulus(1);
    checkOutput({tag, "_swap"}, 32'(swap), 32'd1);
    checkOutput({tag, "_work_full"}, 32'(work_full), 32'd1);
    checkOutput({tag, "_ready_hi"}, 32'(in_ready), 32'd1);
    fillIdx = 1 - fillIdx;
    applyStimulus(1);
    checkOutput({tag, "_swap_one_cycle"}, 32'(swap), 32'd0);
  endtask

  initial begin
    int            ra;
    int            rb;
    int            gAddr;
    logic [31:0]   wa;
    logic [31:0]   wb;
    logic [31:0]   prior7;

    for (int bk = 0; bk < 2; bk++)
      for (int k = 0; k < DEPTH; k++)
        modelMem[bk][k] = '0;
    fillIdx = 0;

    // Reset state
    applyStimulus(3);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_work_full", 32'(work_full), 32'd0);
    checkOutput("rst_swap", 32'(swap), 32'd0);
    checkOutput("rst_collision", 32'(collision), 32'd0);
    checkOutput("rst_overflow", 32'(in_overflow), 32'd0);
    checkOutput("rst_a_valid", 32'(a_valid), 32'd0);
    checkOutput("rst_b_valid", 32'(b_valid), 32'd0);
    checkOutput("rst_a_dout", {a_dout_real, a_dout_imag}, 32'd0);
    rst_n = 1'b1;
    applyStimulus(2);

    // Gated work access before any frame: must not touch memory or raise valid
    gAddr      = 8 + int'($urandom_range(3000));
    a_we       = 1'b1;
    a_re       = 1'b1;
    a_addr     = AW'(gAddr);
    a_din_real = 16'h7abc;
    a_din_imag = 16'h1234;
    applyStimulus(1);
    a_we = 1'b0;
    a_re = 1'b0;
    checkOutput("gate0_a_valid", 32'(a_valid), 32'd0);

    // Frame 1: (k, -k)
    fillFrame(0, DEPTH);
    doneAndSwap("frame1");
    readCheck("f1_rd5", 5, 4095);
    checkOutput("f1_addr5_const", {a_dout_real, a_dout_imag}, 32'h0005_fffb);
    applyStimulus(1);
    checkOutput("f1_valid_drop", 32'(a_valid), 32'd0);
    checkOutput("f1_dout_hold", {a_dout_real, a_dout_imag}, 32'h0005_fffb);

    for (int i = 0; i < 6; i++)
      readCheck("f1_rand_rd", int'($urandom_range(DEPTH-1)), int'($urandom_range(DEPTH-1)));

    // Random two-port writes to distinct addresses, then read back
    for (int i = 0; i < 6; i++) begin
      ra = 8 + int'($urandom_range(DEPTH-9));
      rb = 8 + ((ra - 8 + 1 + int'($urandom_range(DEPTH-10))) % (DEPTH-8));
      wa = $urandom;
      wb = $urandom;
      a_we = 1'b1;
      b_we = 1'b1;
      a_addr = AW'(ra);
      b_addr = AW'(rb);
      {a_din_real, a_din_imag} = wa;
      {b_din_real, b_din_imag} = wb;
      applyStimulus(1);
      a_we = 1'b0;
      b_we = 1'b0;
      checkOutput("wr_no_collision", 32'(collision), 32'd0);
      modelMem[1-fillIdx][ra] = wa;
      modelMem[1-fillIdx][rb] = wb;
      readCheck("wr_readback", ra, rb);
    end

    // Collision and read-during-write at address 7
    prior7 = modelMem[1-fillIdx][7];
    a_we = 1'b1;
    b_we = 1'b1;
    a_re = 1'b1;
    b_re = 1'b1;
    a_addr = AW'(7);
    b_addr = AW'(7);
    {a_din_real, a_din_imag} = 32'h0001_0001;
    {b_din_real, b_din_imag} = 32'h0002_0002;
    applyStimulus(1);
    a_we = 1'b0;
    b_we = 1'b0;
    a_re = 1'b0;
    b_re = 1'b0;
    checkOutput("coll_pulse", 32'(collision), 32'd1);
    checkOutput("rdw_a_old", {a_dout_real, a_dout_imag}, prior7);
    checkOutput("rdw_b_old", {b_dout_real, b_dout_imag}, prior7);
    modelMem[1-fillIdx][7] = 32'h0001_0001;
    applyStimulus(1);
    checkOutput("coll_one_cycle", 32'(collision), 32'd0);
    readCheck("coll_rd7", 7, 7);
    checkOutput("coll_a_wins", {b_dout_real, b_dout_imag}, 32'h0001_0001);

    // Overlap: fill the other bank while work is held
    fillFrame(1, DEPTH);
    checkOutput("ovl_work_held", 32'(work_full), 32'd1);
    in_done = 1'b1;
    applyStimulus(1);
    in_done = 1'b0;
    checkOutput("ovl_first_done_ok", 32'(in_overflow), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput("ovl_no_swap", 32'(swap), 32'd0);
    end

    // Overflow: second in_done, then a write while not ready
    in_done = 1'b1;
    applyStimulus(1);
    in_done = 1'b0;
    checkOutput("ovf_done_pulse", 32'(in_overflow), 32'd1);
    applyStimulus(1);
    checkOutput("ovf_done_one_cycle", 32'(in_overflow), 32'd0);
    in_we = 1'b1;
    in_addr = '0;
    in_real = 16'h7777;
    in_imag = 16'h7777;
    applyStimulus(1);
    in_we = 1'b0;
    checkOutput("ovf_we_pulse", 32'(in_overflow), 32'd1);
    checkOutput("ovf_ready_lo", 32'(in_ready), 32'd0);

    // work_done with pending swap: release first, swap one cycle later
    work_done = 1'b1;
    applyStimulus(1);
    work_done = 1'b0;
    checkOutput("wd_released", 32'(work_full), 32'd0);
    checkOutput("wd_swap_not_yet", 32'(swap), 32'd0);
    applyStimulus(1);
    checkOutput("wd_swap", 32'(swap), 32'd1);
    checkOutput("wd_work_full", 32'(work_full), 32'd1);
    fillIdx = 1 - fillIdx;
    readCheck("ovl_rd0", 0, 4095);
    checkOutput("ovl_addr0_const", {a_dout_real, a_dout_imag}, 32'h0064_0000);
    readCheck("ovl_rand", int'($urandom_range(DEPTH-1)), int'($urandom_range(DEPTH-1)));

    // Gating: release work, then attempt access
    work_done = 1'b1;
    applyStimulus(1);
    work_done = 1'b0;
    checkOutput("gate_released", 32'(work_full), 32'd0);
    a_we = 1'b1;
    b_we = 1'b1;
    a_re = 1'b1;
    b_re = 1'b1;
    a_addr = AW'(gAddr);
    b_addr = AW'(gAddr + 1);
    {a_din_real, a_din_imag} = $urandom;
    {b_din_real, b_din_imag} = $urandom;
    applyStimulus(1);
    a_we = 1'b0;
    b_we = 1'b0;
    a_re = 1'b0;
    b_re = 1'b0;
    checkOutput("gate_a_valid", 32'(a_valid), 32'd0);
    checkOutput("gate_b_valid", 32'(b_valid), 32'd0);

    // Reset in the middle of filling a frame
    fillFrame(2, DEPTH / 2);
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_ready", 32'(in_ready), 32'd1);
    checkOutput("mrst_work_full", 32'(work_full), 32'd0);
    checkOutput("mrst_a_dout", {a_dout_real, a_dout_imag}, 32'd0);
    checkOutput("mrst_b_valid", 32'(b_valid), 32'd0);
    applyStimulus(2);
    rst_n = 1'b1;
    fillIdx = 0;
    applyStimulus(1);

    fillFrame(2, DEPTH);
    doneAndSwap("frame3");
    for (int i = 0; i < 4; i++)
      readCheck("f3_rand_rd", int'($urandom_range(DEPTH-1)), int'($urandom_range(DEPTH-1)));

    // Empty frame in the other bank, then release to bring the gated bank back as work
    in_done = 1'b1;
    applyStimulus(1);
    in_done = 1'b0;
    applyStimulus(1);
    checkOutput("f4_no_swap", 32'(swap), 32'd0);
    work_done = 1'b1;
    applyStimulus(1);
    work_done = 1'b0;
    applyStimulus(1);
    checkOutput("f4_swap", 32'(swap), 32'd1);
    fillIdx = 1 - fillIdx;
    readCheck("gate_mem", gAddr, gAddr + 1);
    checkOutput("gate_mem_const", {a_dout_real, a_dout_imag}, {16'(100 + gAddr), 16'd0});

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/cplx_pingpong_ram.md
Name: cplx_pingpong_ram

Overview:
- Double-buffered complex sample memory for the FFT datapath; generalises the 4096 x 16+16-bit true dual-port RAM.
- Bank "fill" is loaded by the sample input stream. Bank "work" is read and written through two ports by the butterfly engine.
- Banks swap under a fill-done / work-done handshake, so acquisition of frame N+1 overlaps processing of frame N.

Parameters:
- DATA_W, 16, width of each real/imag component (signed)
- ADDR_W, 12, address width; depth per bank = 2**ADDR_W
- OUT_REG, 0, 1 adds a registered output stage (read latency 2 instead of 1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_we  in  1  input-stream write strobe
- in_addr  in  ADDR_W  fill-bank write address
- in_real, in_imag  in  DATA_W each  signed sample
- in_done  in  1  pulse: fill bank holds a complete frame
- in_ready  out  1  fill bank accepts writes
- in_overflow  out  1  1-cycle pulse: write or in_done arrived while in_ready=0
- a_re, a_we  in  1 each  work port A read / write strobes
- a_addr  in  ADDR_W  port A address
- a_din_real, a_din_imag  in  DATA_W each  port A write data
- a_dout_real, a_dout_imag  out  DATA_W each  port A read data
- a_valid  out  1  port A read data valid
- b_re, b_we, b_addr, b_din_real, b_din_imag, b_dout_real, b_dout_imag, b_valid  same as port A, for port B
- work_full  out  1  work bank holds a frame; engine may access it
- work_done  in  1  pulse: engine finished; work bank released
- swap  out  1  1-cycle pulse when banks exchange roles
- collision  out  1  1-cycle pulse: A and B wrote the same address in the same cycle

Behaviour:
- Reset (asynchronous assert, synchronous release) clears:
  - sel and fill_full
  - work_full, swap, collision, in_overflow
  - a_valid, b_valid, and all dout outputs
  - Memory contents are not reset; simulation initialises them to 0.
- sel selects roles: sel=0 means bank0 is fill and bank1 is work. in_ready = !fill_full.
- Input side:
  - in_we with in_ready=1 writes {in_real, in_imag} to fill[in_addr].
  - in_we with in_ready=0 drops the write and pulses in_overflow.
  - in_done sets fill_full. in_done while fill_full=1 pulses in_overflow; state is unchanged.
- Swap rule, evaluated every cycle on registered flags: if fill_full && !work_full, then on the next edge:
  - sel toggles
  - fill_full <= 0, work_full <= 1
  - swap pulses for one cycle
- work_done clears work_full. If work_done and a swap condition occur in the same cycle, work_done takes effect first and the swap follows one cycle later.
- Work ports:
  - Accesses are honoured only while work_full=1. Otherwise writes are dropped, reads are ignored and valid stays 0.
  - Accesses always target the bank selected by sel as registered at the current edge. An access in the swap cycle hits the pre-swap work bank.
- Read latency: 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) from strobe to dout.
  - x_valid is x_re delayed by the same latency, gated by work_full at issue.
  - dout holds its last value when valid=0.
- Read-during-write (same port or cross-port, same address): read returns old data (read-first).
- Both ports write the same address: port A data is stored, port B is discarded, collision pulses.
- Arithmetic: no data arithmetic. Samples are stored as packed {real, imag}, 2*DATA_W bits.
- Reset mid-frame discards all frame state; the next frame starts in bank0 as fill.

Decomposition:
- Package ares_mem_pkg:
  - DATA_W / ADDR_W defaults
  - cplx_t packed struct {real, imag}, signed DATA_W each
- One sub-module, cplx_tdp_bank:
  - one true dual-port, read-first, 2**ADDR_W x cplx_t bank, instantiated twice
  - inferable as block RAM (M10K style attribute, no_rw_check not applied since read-first is required)
- Top level contains sel/flag control, port muxing, A-priority collision logic, valid pipelines and the optional OUT_REG stage.

Test Plan:
- Fill and swap: write addr k = (k, -k) for k=0..4095, pulse in_done -> swap pulses once, work_full=1, in_ready=1; port A read addr 5 -> a_dout = (5, -5), a_valid 1 cycle after a_re (2 cycles with OUT_REG=1).
- Overlap: during work_full=1 fill the new bank with (100+k, 0), pulse in_done -> no swap until work_done; swap follows within 1 cycle; addr 0 reads (100, 0).
- Overflow: in_done twice without work_done, then in_we -> in_overflow pulses, fill contents unchanged, in_ready=0.
- Collision/RDW: A writes (1,1) and B writes (2,2) to addr 7 in the same cycle -> collision pulses, later read gives (1,1); same-cycle read of addr 7 returns the prior value.
- Gating: a_we/a_re with work_full=0 -> memory unchanged, a_valid stays 0.
- Reset mid-frame: assert rst_n=0 while fill is half-written -> all flags and outputs 0, sel=0; the following full frame swaps normally.
